complex_accumulator: RTL and testbench

COMPLEX_ACCUMULATOR -- requirements
Module: complex_accumulator

---
 rtl/complex_accumulator_pkg.sv | 26 ++
 rtl/sample_fifo2.sv | 74 +++++++
 rtl/complex_accumulator.sv | 163 ++++++++++++++++
 tb/tb_complex_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_accumulator_pkg.sv
// Shared filter types and default widths for the complex tap accumulator
// and its output buffer.
package complex_accumulator_pkg;

   localparam int PP_W      = 52;
   localparam int DEF_ACC_W = 58;
   localparam int DEF_SHIFT = 24;
   localparam int DEF_OUT_W = 25;
   localparam int SAT_CNT_W = 16;

   typedef struct packed {
      logic signed [PP_W-1:0] i;
      logic signed [PP_W-1:0] q;
   } Partial_product;

   typedef struct packed {
      logic signed [DEF_OUT_W-1:0] i;
      logic signed [DEF_OUT_W-1:0] q;
   } Out_sample;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry output buffer for finished samples; the head register drives the
// consumer directly so the presented sample stays stable under back-pressure.
module sample_fifo2
   import complex_accumulator_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   output logic      in_ready,
   input  Out_sample in_data,
   output logic      out_valid,
   input  logic      out_ready,
   output Out_sample out_data
);

   Out_sample head_q, head_d;
   Out_sample tail_q, tail_d;
   logic      head_valid_q, head_valid_d;
   logic      tail_valid_q, tail_valid_d;
   logic      push, pop;

   // A full buffer still takes a write when the head leaves in the same cycle.
   assign in_ready = !tail_valid_q || out_ready;
   assign push     = in_valid && in_ready;
   assign pop      = head_valid_q && out_ready;

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      head_valid_d = head_valid_q;
      tail_valid_d = tail_valid_q;
      if (pop) begin
         if (tail_valid_q) begin
            head_d       = tail_q;
            head_valid_d = 1'b1;
            tail_valid_d = push;
            if (push) begin
               tail_d = in_data;
            end
         end else begin
            head_valid_d = push;
            if (push) begin
               head_d = in_data;
            end
         end
      end else if (push) begin
         if (!head_valid_q) begin
            head_d       = in_data;
            head_valid_d = 1'b1;
         end else begin
            tail_d       = in_data;
            tail_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q       <= '0;
         tail_q       <= '0;
         head_valid_q <= 1'b0;
         tail_valid_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         head_valid_q <= head_valid_d;
         tail_valid_q <= tail_valid_d;
      end
   end

   assign out_valid = head_valid_q;
   assign out_data  = head_q;

endmodule

// File: rtl/complex_accumulator.sv
// Accumulates complex partial products over the taps of one output sample,
// then rounds, saturates and buffers the result for a valid/ready consumer.
module complex_accumulator
   import complex_accumulator_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int SHIFT = DEF_SHIFT,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pp_valid,
   input  logic                 pp_first,
   input  logic                 pp_last,
   input  Partial_product       partialProduct,
   output Out_sample            result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SAT_CNT_W-1:0] sat_count,
   output logic                 proto_err,
   output logic                 overrun,
   input  logic                 err_clr
);

   localparam logic signed [ACC_W:0]   HALF    = {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   SAT_MAX = {{(ACC_W+1-OUT_W){1'b0}}, OUT_MAX};
   localparam logic signed [ACC_W:0]   SAT_MIN = {{(ACC_W+1-OUT_W){1'b1}}, OUT_MIN};

   acc_state_e                  state_q, state_d;
   logic signed [ACC_W-1:0]     acc_re_q, acc_re_d;
   logic signed [ACC_W-1:0]     acc_im_q, acc_im_d;
   logic                        done_q, done_d;
   logic                        proto_err_q, proto_err_d;
   logic                        overrun_q, overrun_d;
   logic [SAT_CNT_W-1:0]        sat_count_q, sat_count_d;
   logic [SAT_CNT_W-1:0]        sat_base;
   logic signed [ACC_W-1:0]     pp_re_ext, pp_im_ext;
   logic                        proto_event, overrun_event, sat_event;
   logic                        sat_re, sat_im;
   logic                        fifo_in_ready;
   Out_sample                   rounded;

   // Bias by half an output LSB before the arithmetic shift so ties round up.
   function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                         output logic sat);
      logic signed [ACC_W:0]   biased;
      logic signed [ACC_W:0]   shifted;
      logic signed [OUT_W-1:0] res;
      biased  = {acc[ACC_W-1], acc} + HALF;
      shifted = biased >>> SHIFT;
      if (shifted > SAT_MAX) begin
         sat = 1'b1;
         res = OUT_MAX;
      end else if (shifted < SAT_MIN) begin
         sat = 1'b1;
         res = OUT_MIN;
      end else begin
         sat = 1'b0;
         res = shifted[OUT_W-1:0];
      end
      return res;
   endfunction

   assign pp_re_ext = {{(ACC_W-PP_W){partialProduct.i[PP_W-1]}}, partialProduct.i};
   assign pp_im_ext = {{(ACC_W-PP_W){partialProduct.q[PP_W-1]}}, partialProduct.q};

   // A first beat always restarts the sum; a continuation beat with no open
   // sample is dropped and only flagged.
   always_comb begin
      state_d     = state_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      done_d      = 1'b0;
      proto_event = 1'b0;
      if (pp_valid) begin
         if (pp_first) begin
            acc_re_d    = pp_re_ext;
            acc_im_d    = pp_im_ext;
            proto_event = (state_q == ST_ACC);
            done_d      = pp_last;
            state_d     = pp_last ? ST_IDLE : ST_ACC;
         end else if (state_q == ST_ACC) begin
            acc_re_d = acc_re_q + pp_re_ext;
            acc_im_d = acc_im_q + pp_im_ext;
            done_d   = pp_last;
            state_d  = pp_last ? ST_IDLE : ST_ACC;
         end else begin
            proto_event = 1'b1;
         end
      end
   end

   always_comb begin
      rounded   = '0;
      sat_re    = 1'b0;
      sat_im    = 1'b0;
      rounded.i = round_sat(acc_re_q, sat_re);
      rounded.q = round_sat(acc_im_q, sat_im);
   end

   assign overrun_event = done_q && !fifo_in_ready;
   assign sat_event     = done_q && (sat_re || sat_im);

   // A new error event in the same cycle as err_clr takes precedence.
   always_comb begin
      proto_err_d = proto_err_q;
      overrun_d   = overrun_q;
      sat_base    = sat_count_q;
      if (err_clr) begin
         proto_err_d = 1'b0;
         overrun_d   = 1'b0;
         sat_base    = '0;
      end
      if (proto_event) begin
         proto_err_d = 1'b1;
      end
      if (overrun_event) begin
         overrun_d = 1'b1;
      end
      sat_count_d = sat_base;
      if (sat_event && (sat_base != {SAT_CNT_W{1'b1}})) begin
         sat_count_d = sat_base + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         done_q      <= 1'b0;
         proto_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         done_q      <= done_d;
         proto_err_q <= proto_err_d;
         overrun_q   <= overrun_d;
         sat_count_q <= sat_count_d;
      end
   end

   sample_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (done_q),
      .in_ready  (fifo_in_ready),
      .in_data   (rounded),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (result)
   );

   assign sat_count = sat_count_q;
   assign proto_err = proto_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Scoreboard bench for complex_accumulator: a reference model queues expected
// samples as taps are driven and the monitor compares them on each pop.
module tb_complex_accumulator;
   import complex_accumulator_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           pp_valid = 1'b0;
   logic           pp_first = 1'b0;
   logic           pp_last = 1'b0;
   logic           out_ready = 1'b0;
   logic           err_clr = 1'b0;
   Partial_product partialProduct = '0;
   Out_sample      result;
   logic           out_valid;
   logic           proto_err;
   logic           overrun;
   logic [15:0]    sat_count;

   int        checkCount = 0;
   int        errorCount = 0;
   Out_sample sbQ[$];
   Out_sample monExp;
   longint    sumI = 0;
   longint    sumQ = 0;
   bit        modelOpen = 1'b0;
   bit        expectDrop = 1'b0;
   longint    roundTaps[4];
   longint    roundExp[4];

   complex_accumulator dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pp_valid       (pp_valid),
      .pp_first       (pp_first),
      .pp_last        (pp_last),
      .partialProduct (partialProduct),
      .result         (result),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .sat_count      (sat_count),
      .proto_err      (proto_err),
      .overrun        (overrun),
      .err_clr        (err_clr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic signed [24:0] roundSat(input longint s);
      longint r;
      r = (s + 64'sd8388608) >>> 24;
      if (r > 64'sd16777215) r = 64'sd16777215;
      else if (r < -64'sd16777216) r = -64'sd16777216;
      return r[24:0];
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one beat for a cycle and advance the reference model alongside.
   task automatic applyStimulus(input bit first, input bit last, input longint i, input longint q);
      Out_sample e;
      bit        take;
      pp_valid         = 1'b1;
      pp_first         = first;
      pp_last          = last;
      partialProduct.i = i[51:0];
      partialProduct.q = q[51:0];
      take = 1'b1;
      if (first) begin
         sumI      = i;
         sumQ      = q;
         modelOpen = 1'b1;
      end else if (modelOpen) begin
         sumI += i;
         sumQ += q;
      end else begin
         take = 1'b0;
      end
      if (take && last) begin
         modelOpen = 1'b0;
         e.i = roundSat(sumI);
         e.q = roundSat(sumQ);
         if (!expectDrop) sbQ.push_back(e);
      end
      @(posedge clk);
      #1;
      pp_valid = 1'b0;
      pp_first = 1'b0;
      pp_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_out", 64'(out_valid), 64'(0));
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("result", 64'({result.i, result.q}), 64'({monExp.i, monExp.q}));
         end
      end
   end

   initial begin
      roundTaps[0] = 64'sd8388608;       roundExp[0] = 1;
      roundTaps[1] = 64'sd8388607;       roundExp[1] = 0;
      roundTaps[2] = -64'sd8388608;      roundExp[2] = 0;
      roundTaps[3] = -64'sd8388609;      roundExp[3] = -1;

      #12;
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_result", 64'({result.i, result.q}), 64'(0));
      checkOutput("rst_sat_count", 64'(sat_count), 64'(0));
      checkOutput("rst_proto_err", 64'(proto_err), 64'(0));
      checkOutput("rst_overrun", 64'(overrun), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Four-tap sample and its two-cycle latency
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k == 0, k == 3, 64'sd16777216, -64'sd16777216);
      end
      checkOutput("lat_cycle1", 64'(out_valid), 64'(0));
      idle(1);
      checkOutput("lat_cycle2", 64'(out_valid), 64'(1));
      idle(2);

      // Round-half-up boundaries on single taps
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b1, roundTaps[k], -roundTaps[k]);
         idle(1);
         checkOutput("round_i", 64'(result.i), 64'(roundExp[k]));
         idle(1);
      end

      // Saturation at both rails' limits
      applyStimulus(1'b1, 1'b1, 64'sd1 <<< 48, 64'sd0);
      idle(1);
      checkOutput("sat_pos_i", 64'(result.i), 64'h0000_0000_00FF_FFFF);
      checkOutput("sat_count_1", 64'(sat_count), 64'(1));
      idle(1);
      applyStimulus(1'b1, 1'b1, -(64'sd1 <<< 48) - (64'sd1 <<< 24), 64'sd0);
      idle(1);
      checkOutput("sat_neg_i", 64'(result.i), 64'(-64'sd16777216));
      checkOutput("sat_count_2", 64'(sat_count), 64'(2));
      idle(2);

      // Protocol violations and clear
      checkOutput("proto_clean", 64'(proto_err), 64'(0));
      applyStimulus(1'b1, 1'b0, 64'sd5 <<< 24, 64'sd0);
      applyStimulus(1'b1, 1'b1, 64'sd7 <<< 24, 64'sd0);
      idle(1);
      checkOutput("proto_restart", 64'(proto_err), 64'(1));
      checkOutput("restart_i", 64'(result.i), 64'(7));
      idle(1);
      applyStimulus(1'b0, 1'b1, 64'sd9 <<< 24, 64'sd0);
      idle(3);
      checkOutput("proto_idle", 64'(proto_err), 64'(1));
      checkOutput("ignored_no_out", 64'(out_valid), 64'(0));
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      checkOutput("proto_cleared", 64'(proto_err), 64'(0));
      checkOutput("sat_cleared", 64'(sat_count), 64'(0));

      // Back-pressure, full-buffer drop and pop-with-write
      out_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 64'sd1 <<< 24, 64'sd0);
      applyStimulus(1'b1, 1'b1, 64'sd2 <<< 24, 64'sd0);
      expectDrop = 1'b1;
      applyStimulus(1'b1, 1'b1, 64'sd3 <<< 24, 64'sd0);
      expectDrop = 1'b0;
      idle(2);
      checkOutput("overrun_set", 64'(overrun), 64'(1));
      checkOutput("hold_valid", 64'(out_valid), 64'(1));
      checkOutput("hold_head", 64'(result.i), 64'(1));
      idle(2);
      checkOutput("hold_head_later", 64'(result.i), 64'(1));
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      checkOutput("overrun_cleared", 64'(overrun), 64'(0));
      applyStimulus(1'b1, 1'b1, 64'sd4 <<< 24, 64'sd0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      checkOutput("popwrite_no_overrun", 64'(overrun), 64'(0));
      checkOutput("popwrite_head", 64'(result.i), 64'(2));
      out_ready = 1'b1;
      idle(4);

      // Reset in the middle of an open sample
      out_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 64'sd1 <<< 48, 64'sd0);
      idle(2);
      checkOutput("pre_rst_valid", 64'(out_valid), 64'(1));
      checkOutput("pre_rst_sat", 64'(sat_count), 64'(1));
      applyStimulus(1'b1, 1'b0, 64'sd1 <<< 24, 64'sd0);
      applyStimulus(1'b1, 1'b0, 64'sd2 <<< 24, 64'sd0);
      checkOutput("pre_rst_proto", 64'(proto_err), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 64'(out_valid), 64'(0));
      checkOutput("mid_rst_result", 64'({result.i, result.q}), 64'(0));
      checkOutput("mid_rst_sat", 64'(sat_count), 64'(0));
      checkOutput("mid_rst_proto", 64'(proto_err), 64'(0));
      checkOutput("mid_rst_overrun", 64'(overrun), 64'(0));
      sbQ.delete();
      modelOpen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);
      applyStimulus(1'b0, 1'b1, 64'sd5 <<< 24, 64'sd0);
      idle(1);
      checkOutput("post_rst_proto", 64'(proto_err), 64'(1));
      applyStimulus(1'b1, 1'b0, 64'sd3 <<< 24, 64'sd1 <<< 24);
      applyStimulus(1'b0, 1'b1, 64'sd4 <<< 24, -(64'sd3 <<< 24));
      idle(4);

      checkOutput("sb_drained", 64'(sbQ.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
